// File: rtl/pcm2pdm_mc_if.sv
// PCM-in / PDM-out signal bundle for pcm2pdm_mc; master drives samples and strobes, slave is the converter.
interface pcm2pdm_mc_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 16
);
  logic                      audio_clk;
  logic                      pdm_clk;
  logic                      enable;
  logic                      mute;
  logic [CHANNELS*WIDTH-1:0] sample;
  logic                      clip_clear;
  logic [CHANNELS-1:0]       pdm;
  logic [CHANNELS-1:0]       clip;

  modport master (
    output audio_clk, pdm_clk, enable, mute, sample, clip_clear,
    input  pdm, clip
  );

  modport slave (
    input  audio_clk, pdm_clk, enable, mute, sample, clip_clear,
    output pdm, clip
  );
endinterface

// File: rtl/pcm2pdm_mc.sv
// Multi-channel PCM-to-PDM converter: per-channel clamped sample latch feeding a 1st/2nd-order sigma-delta.
// Optional +/-1 LSB LFSR dither when PCM2PDM_DITHER_EN is defined.
module pcm2pdm_mc #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ORDER    = 2,
  parameter int unsigned GUARD    = 4,
  parameter int unsigned CLAMP    = 3 * (2 ** (WIDTH - 3))
) (
  input  logic          clk,
  input  logic          reset,
  pcm2pdm_mc_if.slave   bus
);

  localparam int unsigned IW = WIDTH + GUARD;
  localparam int unsigned SW = IW + 2;

  typedef logic signed [WIDTH-1:0] smp_t;
  typedef logic signed [IW-1:0]    int_t;
  typedef logic signed [SW-1:0]    ext_t;

  localparam smp_t CLAMP_POS = smp_t'(CLAMP);
  localparam smp_t CLAMP_NEG = -CLAMP_POS;
  localparam ext_t FB_POS    = ext_t'(1) << (WIDTH - 1);
  localparam ext_t FB_NEG    = -FB_POS;
  localparam int_t I_MAX     = {1'b0, {(IW-1){1'b1}}};
  localparam int_t I_MIN     = {1'b1, {(IW-1){1'b0}}};

  if ((ORDER != 1) && (ORDER != 2)) begin : g_order_chk
    $error("pcm2pdm_mc: ORDER must be 1 or 2");
  end

  // Widened sum back to integrator width, pinned at the signed rails.
  function automatic int_t sat(input ext_t v);
    if (v > ext_t'(I_MAX)) return I_MAX;
    if (v < ext_t'(I_MIN)) return I_MIN;
    return int_t'(v);
  endfunction

  smp_t                held_q [CHANNELS];
  smp_t                held_d [CHANNELS];
  int_t                a1_q   [CHANNELS];
  int_t                a1_d   [CHANNELS];
  int_t                a2_q   [CHANNELS];
  int_t                a2_d   [CHANNELS];
  logic [CHANNELS-1:0] pdm_q, pdm_d;
  logic [CHANNELS-1:0] clip_q, clip_d;

`ifdef PCM2PDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  smp_t slice;
  ext_t x;
  ext_t fb;
  int_t n1;
  int_t n2;

  always_comb begin
    held_d = held_q;
    a1_d   = a1_q;
    a2_d   = a2_q;
    pdm_d  = pdm_q;
    clip_d = bus.clip_clear ? '0 : clip_q;
    slice  = '0;
    x      = '0;
    fb     = '0;
    n1     = '0;
    n2     = '0;
`ifdef PCM2PDM_DITHER_EN
    lfsr_d = lfsr_q;
    if (bus.enable && bus.pdm_clk) begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
    end
`endif
    for (int c = 0; c < int'(CHANNELS); c++) begin
      // Modulator step always reads the previously held sample.
      x = bus.mute ? '0 : ext_t'(held_q[c]);
`ifdef PCM2PDM_DITHER_EN
      if (!bus.mute) x = x + (lfsr_q[c] ? ext_t'(1) : -ext_t'(1));
`endif
      fb = pdm_q[c] ? FB_POS : FB_NEG;
      n1 = sat(ext_t'(a1_q[c]) + x - fb);
      n2 = sat(ext_t'(a2_q[c]) + ext_t'(n1) - fb);

      if (!bus.enable) begin
        a1_d[c]  = '0;
        a2_d[c]  = '0;
        pdm_d[c] = 1'b0;
      end else if (bus.pdm_clk) begin
        a1_d[c] = n1;
        if (ORDER == 1) begin
          a2_d[c]  = '0;
          pdm_d[c] = ~n1[IW-1];
        end else begin
          a2_d[c]  = n2;
          pdm_d[c] = ~n2[IW-1];
        end
      end

      // Latch with clamp; a clamp event overrides a same-cycle clear.
      if (bus.audio_clk) begin
        slice = smp_t'(bus.sample[c*WIDTH +: WIDTH]);
        if (slice > CLAMP_POS) begin
          held_d[c] = CLAMP_POS;
          clip_d[c] = 1'b1;
        end else if (slice < CLAMP_NEG) begin
          held_d[c] = CLAMP_NEG;
          clip_d[c] = 1'b1;
        end else begin
          held_d[c] = slice;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= '{default: '0};
      a1_q   <= '{default: '0};
      a2_q   <= '{default: '0};
      pdm_q  <= '0;
      clip_q <= '0;
`ifdef PCM2PDM_DITHER_EN
      lfsr_q <= 16'hACE1;
`endif
    end else begin
      held_q <= held_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      pdm_q  <= pdm_d;
      clip_q <= clip_d;
`ifdef PCM2PDM_DITHER_EN
      lfsr_q <= lfsr_d;
`endif
    end
  end

  assign bus.pdm  = pdm_q;
  assign bus.clip = clip_q;

endmodule

// File: tb/tb_pcm2pdm_mc.sv
// Directed bench for pcm2pdm_mc (2 channels, 16-bit, 2nd order): clip table, bitstream model, density counts.
module tb_pcm2pdm_mc;

  localparam int CH    = 2;
  localparam int W     = 16;
  localparam int TICKS = 1024;
  localparam longint IMAX = 524287;
  localparam longint IMIN = -524288;

  typedef struct {
    logic signed [15:0] s0;
    logic signed [15:0] s1;
    logic               clr;
    logic [1:0]         exp_clip;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pcm2pdm_mc_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  pcm2pdm_mc #(.CHANNELS(CH), .WIDTH(W), .ORDER(2), .GUARD(4), .CLAMP(24576)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int ph_err = 0;
  int cyc_n  = 0;
  int first_cyc;
  logic [3:0] first_act, first_exp;

  longint     m_a1 [CH];
  longint     m_a2 [CH];
  longint     m_held [CH];
  logic [1:0] m_pdm;
  logic [1:0] m_clip;
  logic [15:0] m_lfsr;

  logic [1:0] zref [64];
  logic [1:0] seqa [64];

  function automatic longint msat(input longint v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Closes a phase: every cycle of it compared {clip,pdm} against the model.
  task automatic end_phase(input string name);
    checks++;
    if (ph_err != 0) begin
      errors++;
      $display("FAIL %s: %0d cycles differ, first at cycle %0d got clip,pdm=%b expected %b",
               name, ph_err, first_cyc, first_act, first_exp);
    end
    ph_err = 0;
  endtask

  // Reference behaviour of one clock edge, from the inputs currently driven.
  task automatic model_edge();
    longint x, fb, n1, n2, s;
    logic [1:0] np, nc;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_a1[c] = 0; m_a2[c] = 0; m_held[c] = 0;
      end
      m_pdm  = 2'b00;
      m_clip = 2'b00;
      m_lfsr = 16'hACE1;
    end else begin
      np = m_pdm;
      nc = bus.clip_clear ? 2'b00 : m_clip;
      if (!bus.enable) begin
        for (int c = 0; c < CH; c++) begin
          m_a1[c] = 0; m_a2[c] = 0;
        end
        np = 2'b00;
      end else if (bus.pdm_clk) begin
        for (int c = 0; c < CH; c++) begin
          x = bus.mute ? 0 : m_held[c];
`ifdef PCM2PDM_DITHER_EN
          if (!bus.mute) x = x + (m_lfsr[c] ? 1 : -1);
`endif
          fb = m_pdm[c] ? 32768 : -32768;
          n1 = msat(m_a1[c] + x - fb);
          n2 = msat(m_a2[c] + n1 - fb);
          m_a1[c] = n1;
          m_a2[c] = n2;
          np[c] = (n2 >= 0);
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
      if (bus.audio_clk) begin
        for (int c = 0; c < CH; c++) begin
          s = longint'($signed(bus.sample[c*W +: W]));
          if (s > 24576) begin
            m_held[c] = 24576; nc[c] = 1'b1;
          end else if (s < -24576) begin
            m_held[c] = -24576; nc[c] = 1'b1;
          end else begin
            m_held[c] = s;
          end
        end
      end
      m_pdm  = np;
      m_clip = nc;
    end
  endtask

  task automatic cyc(input logic aclk, input logic pclk);
    bus.audio_clk = aclk;
    bus.pdm_clk   = pclk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_n++;
    bus.audio_clk = 1'b0;
    bus.pdm_clk   = 1'b0;
    if (bus.pdm !== m_pdm || bus.clip !== m_clip) begin
      if (ph_err == 0) begin
        first_cyc = cyc_n;
        first_act = {bus.clip, bus.pdm};
        first_exp = {m_clip, m_pdm};
      end
      ph_err++;
    end
  endtask

  task automatic tick(output logic [1:0] p);
    cyc(1'b0, 1'b1);
    p = bus.pdm;
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    logic [1:0] p;
    int ones0, ones1, mm;

    vecs[0] = '{16'sd0,      16'sd0,      1'b0, 2'b00};
    vecs[1] = '{16'sd24576,  -16'sd24576, 1'b0, 2'b00};
    vecs[2] = '{16'sd24577,  16'sd0,      1'b0, 2'b01};
    vecs[3] = '{16'sd0,      16'sd0,      1'b0, 2'b01};
    vecs[4] = '{16'sd0,      16'sd0,      1'b1, 2'b00};
    vecs[5] = '{16'sd0,      -16'sd24577, 1'b0, 2'b10};
    vecs[6] = '{16'sd32767,  -16'sd32768, 1'b1, 2'b11};
    vecs[7] = '{16'sd0,      16'sd0,      1'b1, 2'b00};
    vecs[8] = '{-16'sd24576, 16'sd100,    1'b0, 2'b00};

    reset          = 1'b1;
    bus.audio_clk  = 1'b0;
    bus.pdm_clk    = 1'b0;
    bus.enable     = 1'b0;
    bus.mute       = 1'b0;
    bus.sample     = '0;
    bus.clip_clear = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset(3);
    chk("rst_pdm", bus.pdm, 0);
    chk("rst_clip", bus.clip, 0);
    end_phase("reset_stream");

    // Clamp / sticky-clip table
    for (int i = 0; i < 9; i++) begin
      bus.sample     = {vecs[i].s1, vecs[i].s0};
      bus.clip_clear = vecs[i].clr;
      cyc(1'b1, 1'b0);
      bus.clip_clear = 1'b0;
      chk($sformatf("clip_tbl[%0d]", i), bus.clip, vecs[i].exp_clip);
    end
    end_phase("clip_tbl_stream");

    // Zero input: half density
    do_reset(2);
    bus.enable = 1'b1;
    bus.sample = '0;
    cyc(1'b1, 1'b0);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < TICKS; i++) begin
      tick(p);
      if (i < 64) zref[i] = p;
      ones0 += p[0]; ones1 += p[1];
    end
    chk_rng("zero_ones0", ones0, 510, 514);
    chk_rng("zero_ones1", ones1, 510, 514);
    chk("zero_clip", bus.clip, 0);
    end_phase("zero_stream");

    // +/- half scale, independent channels
    do_reset(2);
    bus.sample = {-16'sd16384, 16'sd16384};
    cyc(1'b1, 1'b0);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < TICKS; i++) begin
      tick(p);
      ones0 += p[0]; ones1 += p[1];
    end
    chk_rng("half_ones0", ones0, 765, 771);
    chk_rng("half_ones1", ones1, 253, 259);
    end_phase("half_stream");

    // Clamped full scale, then clear
    do_reset(2);
    bus.sample = {16'sd0, 16'sd32767};
    cyc(1'b1, 1'b0);
    chk("clamp_clip", bus.clip, 2'b01);
    ones0 = 0;
    for (int i = 0; i < TICKS; i++) begin
      tick(p);
      ones0 += p[0];
    end
    chk_rng("clamp_ones0", ones0, 892, 900);
    chk("clamp_clip_sticky", bus.clip, 2'b01);
    bus.clip_clear = 1'b1;
    cyc(1'b0, 1'b0);
    bus.clip_clear = 1'b0;
    chk("clip_clear", bus.clip, 0);
    end_phase("clamp_stream");

    // Mute: nonzero held sample must behave like zero input
    do_reset(2);
    bus.sample = {16'sd16384, 16'sd16384};
    bus.mute   = 1'b1;
    cyc(1'b1, 1'b0);
    mm = 0;
    for (int i = 0; i < 64; i++) begin
      tick(p);
      if (p !== zref[i]) mm++;
    end
    bus.mute = 1'b0;
    chk("mute_vs_zero", mm, 0);
    end_phase("mute_stream");

    // Same-cycle latch and tick: tick uses the old (zero) sample
    do_reset(2);
    bus.sample = '0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(p);
    bus.sample = {16'sd0, 16'sd8000};
    cyc(1'b1, 1'b1);
    chk("simul_uses_old", bus.pdm, zref[20]);
    repeat (3) cyc(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(p);
    end_phase("simul_stream");

    // Enable drop, then restart from clean state
    do_reset(2);
    bus.sample = {-16'sd12000, 16'sd5000};
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tick(p);
      seqa[i] = p;
    end
    for (int i = 0; i < 100; i++) tick(p);
    bus.enable = 1'b0;
    mm = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i % 4) == 0);
      if (bus.pdm !== 2'b00) mm++;
    end
    chk("dis_pdm_zero", mm, 0);
    bus.enable = 1'b1;
    mm = 0;
    for (int i = 0; i < 64; i++) begin
      tick(p);
      if (p !== seqa[i]) mm++;
    end
    chk("reenable_match", mm, 0);
    end_phase("enable_stream");

    // One-cycle reset mid-run
    do_reset(2);
    bus.sample = {16'sd0, 16'sd30000};
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) tick(p);
    bus.sample = {16'sd20000, 16'sd20000};
    reset = 1'b1;
    cyc(1'b0, 1'b1);
    reset = 1'b0;
    chk("midrst_pdm", bus.pdm, 0);
    chk("midrst_clip", bus.clip, 0);
    repeat (3) cyc(1'b0, 1'b0);
    mm = 0;
    for (int i = 0; i < 64; i++) begin
      tick(p);
      if (p !== zref[i]) mm++;
    end
    chk("midrst_held_zero", mm, 0);
    end_phase("midrst_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm2pdm_mc.md
Name: pcm2pdm_mc

Overview:
- Multi-channel, parametrised successor to the single-channel PCM-to-PDM converter.
- Converts CHANNELS independent signed PCM streams into 1-bit PDM streams using a first- or second-order sigma-delta modulator per channel.
- Sits between the sample sources (oscillators/mixer) and the PDM output pins.
- Runs on the system clock, gated by the audio_clk and pdm_clk single-cycle enable strobes from clock_gen.

Parameters:
- CHANNELS, 2, number of independent channels (1..8)
- WIDTH, 16, PCM sample width, signed two's complement
- ORDER, 2, modulator order; only 1 and 2 are legal (other values: elaboration error)
- GUARD, 4, extra integrator bits above WIDTH; integrator width IW = WIDTH+GUARD
- CLAMP, 3*2**(WIDTH-3), input magnitude limit; 24576 when WIDTH=16

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- audio_clk  in  1  one-cycle strobe; latch new samples
- pdm_clk  in  1  one-cycle strobe; advance modulators one PDM bit
- enable  in  1  modulator run enable
- mute  in  1  force modulator input to 0
- sample  in  CHANNELS*WIDTH  packed PCM; channel c occupies bits [c*WIDTH +: WIDTH]
- clip_clear  in  1  clear all sticky clip flags
- pdm  out  CHANNELS  PDM bit per channel
- clip  out  CHANNELS  sticky per-channel clamp-occurred flag

Behaviour:
- Reset: held samples=0, integrators=0, pdm=0, clip=0. While reset is high, every other input is ignored.
- Sample latch: on a cycle with audio_clk=1, each channel's held sample <= sample slice.
- Clamp on latch: if the slice > CLAMP, hold CLAMP; if < -CLAMP, hold -CLAMP. Either case sets clip[c] in the same edge.
- clip is sticky until clip_clear=1. If clip_clear and a new clamp happen in the same cycle, set wins.
- Modulator input x: x = mute ? 0 : held sample.
- Feedback fb: +2**(WIDTH-1) if the channel's current pdm=1, otherwise -2**(WIDTH-1). Operands are sign-extended to IW.
- Update on a cycle with pdm_clk=1 and enable=1:
  - ORDER=1: a1 <= a1 + x - fb; pdm <= (a1_next >= 0).
  - ORDER=2: a1 <= a1 + x - fb; a2 <= a2 + a1_next - fb; pdm <= (a2_next >= 0).
  - Integrators saturate at IW-bit signed limits; they never wrap.
- Latency:
  - pdm changes on the clk edge that samples pdm_clk=1 (registered output, visible the next cycle).
  - A sample latched by audio_clk first affects the next pdm_clk tick strictly after the latch edge.
- Simultaneous audio_clk and pdm_clk: the modulator uses the previously held sample; the new sample takes effect on the following tick.
- enable=0: integrators are cleared to 0 and pdm is forced to 0 on every edge. Sample latching and clip logic keep running. Modulation resumes on the first pdm_clk after enable returns to 1, starting from the reset state.
- pdm_clk with enable=0 has no effect. There are no other state machines; every channel is identical and independent.
- Reset mid-stream: the next edge returns all state to reset values. pdm is low the cycle after reset is sampled.

Optional Feature:
- Macro PCM2PDM_DITHER_EN.
- Defined:
  - One shared 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances on every enabled pdm_clk tick.
  - Channel c adds LFSR bit c (a value in {0,1}) to x as a ±1 LSB dither: +1 if the bit is set, -1 if clear.
  - Dither is not applied when mute=1.
- Undefined: no LFSR is present, and x is exactly as specified above.

Test Plan:
- WIDTH=16, ORDER=2, enable=1, sample=0 on all channels, pdm_clk every 4 clk, 1024 ticks -> each channel's count of ones is 512±2; clip stays 0.
- ch0=+16384, ch1=-16384, latched once -> over 1024 ticks, ch0 count of ones is 768±3 and ch1 is 256±3; channels do not interact.
- ch0=32767 latched -> ch0 holds 24576 and clip[0]=1 the cycle after the latch; count of ones is 896±4 over 1024 ticks. Then pulse clip_clear -> clip[0]=0.
- audio_clk and pdm_clk in the same cycle with a new value 8000 replacing 0 -> that tick's update uses 0 (checked against a reference model); the next tick uses 8000.
- Mid-run, drop enable for 10 cycles -> pdm=0 throughout and integrators=0; after re-enable, the bitstream matches a fresh run from reset bit-for-bit.
- Assert reset for 1 cycle mid-run -> pdm=0 and clip=0 the next cycle; held samples read 0 until the next audio_clk.
